mult_div_unit: RTL and testbench

// E-stage multiply/divide unit owning the HI/LO registers. It produces the busy and

---
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 tb/tb_mult_div_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; exposes busy/remaining-latency for D-stage stalls
// and serves mfhi/mflo combinationally.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        req,
    output logic        md_busy,
    output logic [31:0] md_tnew,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    state_e      state_q, state_d;
    logic [31:0] tnew_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic [31:0] hi_q, lo_q;

    logic        idle_ok;
    logic        start;
    logic        is_div;
    logic        commit;
    logic [31:0] res_hi, res_lo;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic signed [31:0] quo_s, rem_s;

    assign idle_ok = !req && (state_q == StIdle);
    assign start   = idle_ok && (md_op >= OpMult) && (md_op <= OpDivu);
    assign is_div  = (md_op == OpDiv) || (md_op == OpDivu);
    assign commit  = (state_q == StBusy) && (tnew_q == 32'd1);

    assign prod_s = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
    assign prod_u = {32'b0, md_a} * {32'b0, md_b};

    always_comb begin
        quo_s = '0;
        rem_s = '0;
        if (md_b == 32'd0) begin
            quo_s = '0;
            rem_s = '0;
        end else if (md_a == 32'h8000_0000 && md_b == 32'hFFFF_FFFF) begin
            quo_s = $signed(md_a);
            rem_s = '0;
        end else begin
            quo_s = $signed(md_a) / $signed(md_b);
            rem_s = $signed(md_a) % $signed(md_b);
        end
    end

    // Divide by zero keeps the current HI/LO, which cannot change while busy.
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (md_op)
            OpMult:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OpMultu: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OpDiv: begin
                if (md_b != 32'd0) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            OpDivu: begin
                if (md_b != 32'd0) begin
                    res_hi = md_a % md_b;
                    res_lo = md_a / md_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (tnew_q == 32'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        md_busy = (state_q == StBusy);
        md_out  = 32'd0;
        if (md_op == OpMfhi)      md_out = hi_q;
        else if (md_op == OpMflo) md_out = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tnew_q    <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (start) begin
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                tnew_q    <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
            end else if (state_q == StBusy) begin
                tnew_q <= tnew_q - 32'd1;
            end
            if (commit) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end else if (idle_ok && md_op == OpMthi) begin
                hi_q <= md_a;
            end else if (idle_ok && md_op == OpMtlo) begin
                lo_q <= md_a;
            end
        end
    end

    assign md_tnew = tnew_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected commits and reads into queues,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;    // expected busy length
        int          rem;  // countdown left when busy drops (nonzero only for a reset abandon)
    } commit_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] md_a = '0;
    logic [31:0] md_b = '0;
    logic        req = 1'b0;
    logic        md_busy;
    logic [31:0] md_tnew, md_out, hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    commit_t     exp_q[$];
    logic [31:0] rd_q[$];
    logic        busy_prev = 1'b0;
    int          cnt = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .md_op   (md_op),
        .md_a    (md_a),
        .md_b    (md_b),
        .req     (req),
        .md_busy (md_busy),
        .md_tnew (md_tnew),
        .md_out  (md_out),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    // Monitor: busy countdown, commit results and mfhi/mflo reads.
    always @(negedge clk) begin
        if (md_busy === 1'b1 && !busy_prev) begin
            if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
            else cnt = exp_q[0].n;
        end
        if (md_busy === 1'b1) begin
            chk("tnew_count", md_tnew, 32'(cnt));
            cnt--;
        end
        if (md_busy === 1'b0 && busy_prev) begin
            chk("tnew_idle", md_tnew, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 32'd1, 32'd0);
            end else begin
                commit_t e;
                e = exp_q.pop_front();
                chk("busy_remaining", 32'(cnt), 32'(e.rem));
                chk("commit_hi", hi, e.hi);
                chk("commit_lo", lo, e.lo);
            end
        end
        if (md_op == 4'd7 || md_op == 4'd8) begin
            if (rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
            else chk(md_op == 4'd7 ? "mfhi" : "mflo", md_out, rd_q.pop_front());
        end
        busy_prev = (md_busy === 1'b1);
    end

    // Drive one op for one edge, then return to idle inputs at #1 after that edge.
    task automatic op_cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic r);
        md_op = op; md_a = a; md_b = b; req = r;
        @(posedge clk); #1;
        md_op = 4'd0; req = 1'b0;
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input int n);
        commit_t e;
        e.hi = ehi; e.lo = elo; e.n = n; e.rem = 0;
        exp_q.push_back(e);
        op_cycle(op, a, b, 1'b0);
    endtask

    task automatic rd(input logic [3:0] op, input logic [31:0] exp);
        rd_q.push_back(exp);
        op_cycle(op, '0, '0, 1'b0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (md_busy === 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 40) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", {31'b0, md_busy}, 32'd0);
        chk("reset_tnew", md_tnew, 32'd0);
        rd(4'd7, 32'h0);
        rd(4'd8, 32'h0);

        start_op(4'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
        wait_idle();
        rd(4'd7, 32'hFFFF_FFFF);
        rd(4'd8, 32'hFFFF_FFF1);

        start_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        wait_idle();

        // Second start while busy must be ignored.
        start_op(4'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
        op_cycle(4'd1, 32'd2, 32'd3, 1'b0);
        wait_idle();

        start_op(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        wait_idle();

        start_op(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_idle();

        // Divide by zero, with an mtlo while busy that must also be ignored.
        op_cycle(4'd5, 32'hAAAA_0000, '0, 1'b0);
        op_cycle(4'd6, 32'h0000_BBBB, '0, 1'b0);
        start_op(4'd4, 32'd5, 32'd0, 32'hAAAA_0000, 32'h0000_BBBB, 10);
        op_cycle(4'd6, 32'h0000_1234, '0, 1'b0);
        wait_idle();
        rd(4'd7, 32'hAAAA_0000);
        rd(4'd8, 32'h0000_BBBB);

        start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
        wait_idle();

        op_cycle(4'd5, 32'h1234_5678, '0, 1'b1);
        rd(4'd7, 32'h0);
        op_cycle(4'd5, 32'h1234_5678, '0, 1'b0);
        rd(4'd7, 32'h1234_5678);

        op_cycle(4'd1, 32'd6, 32'd7, 1'b1);
        chk("req_blocks_start", {31'b0, md_busy}, 32'd0);

        // req while in flight does not cancel.
        start_op(4'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5);
        req = 1'b1;
        repeat (3) @(posedge clk);
        #1 req = 1'b0;
        wait_idle();

        // Reset at tnew=3 abandons the divide.
        begin
            commit_t e;
            e.hi = '0; e.lo = '0; e.n = 10; e.rem = 2;
            exp_q.push_back(e);
        end
        op_cycle(4'd3, 32'd100, 32'd7, 1'b0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abandon_busy", {31'b0, md_busy}, 32'd0);
        repeat (15) @(posedge clk);
        #1;
        rd(4'd7, 32'h0);
        rd(4'd8, 32'h0);

        repeat (2) @(posedge clk);
        chk("commits_left", 32'(exp_q.size()), 32'd0);
        chk("reads_left", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
